// File: rtl/traffic_signal_controller_ped_if.sv
// Signal bundle between the intersection controller and its environment:
// sensor/button/delay inputs toward the controller, signal heads back out.
interface traffic_signal_controller_ped_if #(
    parameter int DW = 4
);
    logic          x;
    logic          ped_req;
    logic [DW-1:0] y2rdelay;
    logic [DW-1:0] r2gdelay;
    logic [DW-1:0] maxgreen;
    logic [DW-1:0] walkdelay;
    logic [1:0]    hwy;
    logic [1:0]    cntry;
    logic          walk;
    logic [2:0]    state;

    modport master (
        output x, ped_req, y2rdelay, r2gdelay, maxgreen, walkdelay,
        input  hwy, cntry, walk, state
    );

    modport slave (
        input  x, ped_req, y2rdelay, r2gdelay, maxgreen, walkdelay,
        output hwy, cntry, walk, state
    );
endinterface

// File: rtl/traffic_signal_controller_ped.sv
// Highway/country-road signal controller with max-green timeout, minimum
// highway hold and a latched pedestrian request served in an all-red walk phase.
module traffic_signal_controller_ped #(
    parameter int DW            = 4,
    parameter int HWY_MIN_GREEN = 4
) (
    input logic                         clock,
    input logic                         clear,
    traffic_signal_controller_ped_if.slave bus
);

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6
    } state_t;

    localparam logic [1:0]    RED     = 2'd0;
    localparam logic [1:0]    YELLOW  = 2'd1;
    localparam logic [1:0]    GREEN   = 2'd2;
    localparam logic [DW-1:0] ONE     = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] CNT_MAX = {DW{1'b1}};
    localparam logic [DW-1:0] HOLD    = DW'(HWY_MIN_GREEN - 1);

    state_t        state_r;
    state_t        state_next_s;
    logic [DW-1:0] cnt_r;
    logic [DW-1:0] cnt_next_s;
    logic          ped_pend_r;
    logic          ped_pend_next_s;
    logic [1:0]    hwy_r;
    logic [1:0]    cntry_r;
    logic          walk_r;

    // A zero delay still holds its state for one cycle, so compare against eff(D)-1.
    function automatic logic [DW-1:0] eff_m1(input logic [DW-1:0] d);
        if (d == {DW{1'b0}}) begin
            eff_m1 = {DW{1'b0}};
        end else begin
            eff_m1 = d - ONE;
        end
    endfunction

    function automatic logic [1:0] hwy_of(input state_t s);
        case (s)
            S0:      hwy_of = GREEN;
            S1:      hwy_of = YELLOW;
            default: hwy_of = RED;
        endcase
    endfunction

    function automatic logic [1:0] cntry_of(input state_t s);
        case (s)
            S3:      cntry_of = GREEN;
            S4:      cntry_of = YELLOW;
            default: cntry_of = RED;
        endcase
    endfunction

    function automatic logic walk_of(input state_t s);
        case (s)
            S6:      walk_of = 1'b1;
            default: walk_of = 1'b0;
        endcase
    endfunction

    // Next-state selection from live delay inputs and the dwell count
    always_comb begin
        state_next_s = S0;
        case (state_r)
            S0: begin
                if ((cnt_r >= HOLD) && (bus.x || ped_pend_r)) state_next_s = S1;
                else                                          state_next_s = S0;
            end
            S1: begin
                if (cnt_r >= eff_m1(bus.y2rdelay)) state_next_s = S2;
                else                               state_next_s = S1;
            end
            S2: begin
                if (cnt_r >= eff_m1(bus.r2gdelay)) begin
                    if (bus.x)           state_next_s = S3;
                    else if (ped_pend_r) state_next_s = S6;
                    else                 state_next_s = S0;
                end else begin
                    state_next_s = S2;
                end
            end
            S3: begin
                if (!bus.x || (cnt_r >= eff_m1(bus.maxgreen))) state_next_s = S4;
                else                                           state_next_s = S3;
            end
            S4: begin
                if (cnt_r >= eff_m1(bus.y2rdelay)) state_next_s = S5;
                else                               state_next_s = S4;
            end
            S5: begin
                if (cnt_r >= eff_m1(bus.r2gdelay)) begin
                    if (ped_pend_r) state_next_s = S6;
                    else            state_next_s = S0;
                end else begin
                    state_next_s = S5;
                end
            end
            S6: begin
                if (cnt_r >= eff_m1(bus.walkdelay)) state_next_s = S0;
                else                                state_next_s = S6;
            end
            default: state_next_s = S0;
        endcase
    end

    // Pedestrian latch: entering the walk phase wins over a simultaneous press
    always_comb begin
        ped_pend_next_s = ped_pend_r;
        if (state_next_s == S6) begin
            ped_pend_next_s = 1'b0;
        end else if (bus.ped_req && (state_r != S6)) begin
            ped_pend_next_s = 1'b1;
        end else begin
            ped_pend_next_s = ped_pend_r;
        end
    end

    // Dwell counter restarts on each state change and saturates otherwise
    always_comb begin
        cnt_next_s = cnt_r;
        if (state_next_s != state_r) begin
            cnt_next_s = {DW{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_next_s = cnt_r + ONE;
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // State, counter, latch and head registers; heads decode the next state
    // so they switch on the same edge as the state register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_r    <= S0;
            cnt_r      <= {DW{1'b0}};
            ped_pend_r <= 1'b0;
            hwy_r      <= GREEN;
            cntry_r    <= RED;
            walk_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            ped_pend_r <= ped_pend_next_s;
            hwy_r      <= hwy_of(state_next_s);
            cntry_r    <= cntry_of(state_next_s);
            walk_r     <= walk_of(state_next_s);
        end
    end

    assign bus.hwy   = hwy_r;
    assign bus.cntry = cntry_r;
    assign bus.walk  = walk_r;
    assign bus.state = state_r;

endmodule
